// File: rtl/spi_flash_arbiter.sv
// Two-port SPI flash read arbiter: round-robin grant, 0x03 read, mode-0 SCLK.
// Define SPI_FLASH_ARBITER_FAST_READ_EN for 0x0B fast read with 8 dummy bits.
module spi_flash_arbiter #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        chip_select,
    output logic        data_clk,
    output logic        spi_si,
    input  logic        spi_so
);

`ifdef SPI_FLASH_ARBITER_FAST_READ_EN
    localparam logic [7:0] RD_CMD = 8'h0B;
    localparam int         NBITS  = 72;
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, DESEL
    } state_t;
`else
    localparam logic [7:0] RD_CMD = 8'h03;
    localparam int         NBITS  = 64;
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, DESEL
    } state_t;
`endif

    localparam logic [8:0] RISE_M1 = 9'(CLK_DIV - 1);
    localparam logic [8:0] SAMPLE  = 9'(CLK_DIV);
    localparam logic [8:0] LASTC   = 9'(2 * CLK_DIV - 1);
    localparam logic [6:0] LASTB   = 7'(NBITS - 1);

    state_t      state_q;
    logic [8:0]  cnt_q;
    logic [6:0]  bit_q;
    logic [30:0] tx_q;
    logic [31:0] rx_q;
    logic [31:0] rdata_q;
    logic [1:0]  desel_q;
    logic        sel_q;
    logic        last_q;
    logic        cs_q;
    logic        sclk_q;
    logic        si_q;
    logic        ack0_q;
    logic        ack1_q;

    logic        grant1;
    logic        bit_end;
    logic [6:0]  nbit;
    logic [31:0] rx_d;

    // last_q set means req1 was served last, so a tie goes to req0
    assign grant1  = req1 && (!req0 || !last_q);
    assign bit_end = (cnt_q == LASTC);
    assign nbit    = bit_q + 7'd1;
    assign rx_d    = (state_q == DATA && cnt_q == SAMPLE)
                   ? {rx_q[30:0], spi_so} : rx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            desel_q <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            si_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            rx_q   <= rx_d;
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        sel_q   <= grant1;
                        last_q  <= grant1;
                        tx_q    <= {RD_CMD[6:0], grant1 ? addr1 : addr0};
                        si_q    <= RD_CMD[7];
                        cs_q    <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= CMD;
                    end
                end
                DESEL: begin
                    if (desel_q == 2'd2) begin
                        state_q <= IDLE;
                    end else begin
                        desel_q <= desel_q + 2'd1;
                    end
                end
                default: begin
                    if (cnt_q == RISE_M1) begin
                        sclk_q <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        bit_q  <= nbit;
                        tx_q   <= {tx_q[29:0], 1'b0};
                        si_q   <= (nbit < 7'd32) ? tx_q[30] : 1'b0;
                        if (bit_q == LASTB) begin
                            state_q <= DESEL;
                            desel_q <= '0;
                            cs_q    <= 1'b1;
                            si_q    <= 1'b0;
                            ack0_q  <= !sel_q;
                            ack1_q  <= sel_q;
                            rdata_q <= {rx_d[7:0], rx_d[15:8],
                                        rx_d[23:16], rx_d[31:24]};
                        end else if (bit_q == 7'd7) begin
                            state_q <= ADDR;
`ifdef SPI_FLASH_ARBITER_FAST_READ_EN
                        end else if (bit_q == 7'd31) begin
                            state_q <= DUMMY;
                        end else if (bit_q == 7'd39) begin
                            state_q <= DATA;
`else
                        end else if (bit_q == 7'd31) begin
                            state_q <= DATA;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata       = rdata_q;
    assign busy        = (state_q != IDLE);
    assign chip_select = cs_q;
    assign data_clk    = sclk_q;
    assign spi_si      = si_q;

endmodule
